stepper_seq_ctrl: RTL and testbench



---
 rtl/stepper_seq_ctrl_pkg.sv | 38 +++
 rtl/stepper_seq_ctrl_if.sv | 40 ++++
 rtl/stepper_seq_ctrl_step_rate_div.sv | 27 ++
 rtl/stepper_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_stepper_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_seq_ctrl_pkg.sv
// Shared types and constants for the stepping-motor sequencer.
package stepper_pkg;

  // Sequencer states; exported on the debug port so checkers can bind to them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Coil patterns {A,B,C,D}; entry i sits at PHASE_TABLE[i].
  // Even indices energize one coil, odd indices energize two (half-step points).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  // Phase-index increment per step, which equals the position increment in half-step units.
  localparam logic [2:0] FULL_INC = 3'd2;
  localparam logic [2:0] HALF_INC = 3'd1;

  // Next phase index; the 3-bit width gives the modulo-8 wrap for free,
  // and a full step moves by 2 so index parity is preserved.
  function automatic logic [2:0] next_phase(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
    logic [2:0] inc;
    inc = half ? HALF_INC : FULL_INC;
    return dir ? (idx + inc) : (idx - inc);
  endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// Command / status bundle for the stepping-motor sequencer.
//
// Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready
// are both high. cmd_ready is high only while the sequencer is idle, so at most
// one command is in flight. The command fields are sampled only on that edge
// and ignored at every other time. Completion is reported by a one-cycle done
// pulse, and aborted qualifies that pulse.
interface stepper_seq_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8,
  parameter int POS_W = 32
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CNT_W-1:0]        cmd_steps;
  logic                    cmd_dir;
  logic                    cmd_half;
  logic [DIV_W-1:0]        cmd_div;
  logic                    abort;
  logic [3:0]              coil;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic signed [POS_W-1:0] pos;
  stepper_pkg::state_t     fsm_state;

  // Command source side (controller or testbench).
  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_div, abort,
    input  cmd_ready, coil, busy, done, aborted, pos, fsm_state
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_div, abort,
    output cmd_ready, coil, busy, done, aborted, pos, fsm_state
  );

endinterface

// File: rtl/stepper_seq_ctrl_step_rate_div.sv
// Rate prescaler: passes one of every (div+1) step_tick pulses as step_en.
module step_rate_div #(
  parameter int DIV_W = 8
) (
  input  logic             fpga_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step_tick,
  input  logic [DIV_W-1:0] div,
  output logic             step_en
);

  logic [DIV_W-1:0] div_cnt;

  // The tick that finds the counter at the terminal value is the one passed on.
  assign step_en = step_tick && (div_cnt == div);

  // Count ticks; clr restarts the count for a freshly accepted command.
  always_ff @(posedge fpga_clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
    end else if (step_tick) begin
      div_cnt <= step_en ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Command-driven sequencer for a 4-wire unipolar stepping motor.
// Accepts one move command at a time, walks the coil phase table at a
// prescaled step rate, tracks absolute position and reports completion.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 8,
  parameter int POS_W   = 32,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic               fpga_clk,
  input  logic               rst,
  input  logic               step_tick,
  stepper_seq_ctrl_if.slave  bus
);

  // Architectural state.
  state_t           state;
  logic [2:0]       phase_idx;
  logic             energized;
  logic [CNT_W-1:0] remaining;
  logic [POS_W-1:0] pos_q;
  logic             aborted_q;
  logic [3:0]       coil_q;

  // Command fields captured at acceptance.
  logic             dir_q;
  logic             half_q;
  logic [DIV_W-1:0] div_q;

  // Next-state values.
  state_t           state_nx;
  logic [2:0]       phase_nx;
  logic             energized_nx;
  logic [CNT_W-1:0] remaining_nx;
  logic [POS_W-1:0] pos_nx;
  logic             aborted_nx;

  logic             accept;
  logic             run_tick;
  logic             step_en;
  logic [POS_W-1:0] pos_step;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  // Abort outranks a coincident tick, so the prescaler never sees that tick.
  assign run_tick = step_tick && (state == RUN) && !bus.abort;
  assign pos_step = half_q ? POS_W'(HALF_INC) : POS_W'(FULL_INC);

  step_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .fpga_clk  (fpga_clk),
    .rst       (rst),
    .clr       (accept),
    .step_tick (run_tick),
    .div       (div_q),
    .step_en   (step_en)
  );

  // Next-state and datapath decisions for the sequencer FSM.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase_idx;
    energized_nx = energized;
    remaining_nx = remaining;
    pos_nx       = pos_q;
    aborted_nx   = aborted_q;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          aborted_nx   = 1'b0;
          remaining_nx = bus.cmd_steps;
          // A zero-length move completes without any motion.
          state_nx     = (bus.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          aborted_nx = 1'b1;
          state_nx   = DONE;
        end else if (step_en) begin
          phase_nx     = next_phase(phase_idx, dir_q, half_q);
          energized_nx = 1'b1;
          pos_nx       = dir_q ? (pos_q + pos_step) : (pos_q - pos_step);
          // remaining is nonzero throughout RUN, so this cannot underflow.
          remaining_nx = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx   = IDLE;
        aborted_nx = 1'b0;
        if (!HOLD_EN) begin
          energized_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State registers; coil is registered from the next phase so a new
  // pattern appears in the cycle right after the stepping tick.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_idx <= 3'd0;
      energized <= 1'b0;
      remaining <= '0;
      pos_q     <= '0;
      aborted_q <= 1'b0;
      coil_q    <= 4'b0000;
    end else begin
      state     <= state_nx;
      phase_idx <= phase_nx;
      energized <= energized_nx;
      remaining <= remaining_nx;
      pos_q     <= pos_nx;
      aborted_q <= aborted_nx;
      coil_q    <= energized_nx ? PHASE_TABLE[phase_nx] : 4'b0000;
    end
  end

  // Command capture; fields are only sampled on the accepting edge.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      dir_q  <= 1'b0;
      half_q <= 1'b0;
      div_q  <= '0;
    end else if (accept) begin
      dir_q  <= bus.cmd_dir;
      half_q <= bus.cmd_half;
      div_q  <= bus.cmd_div;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.aborted   = aborted_q;
  assign bus.pos       = pos_q;
  assign bus.coil      = coil_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Testbench for stepper_seq_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model. A second instance built
// with POS_W=4 and HOLD_EN=0 receives the same stimulus.
module tb_stepper_seq_ctrl;
  import stepper_pkg::*;

  // ---------------- clock / reset ----------------
  logic fpga_clk = 1'b0;
  logic rst = 1'b1;
  logic step_tick = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  stepper_seq_ctrl_if #(.CNT_W(16), .DIV_W(8), .POS_W(32)) bus ();
  stepper_seq_ctrl_if #(.CNT_W(16), .DIV_W(8), .POS_W(4))  bus_s ();

  stepper_seq_ctrl #(.CNT_W(16), .DIV_W(8), .POS_W(32), .HOLD_EN(1'b1)) u_dut (
    .fpga_clk  (fpga_clk),
    .rst       (rst),
    .step_tick (step_tick),
    .bus       (bus)
  );

  stepper_seq_ctrl #(.CNT_W(16), .DIV_W(8), .POS_W(4), .HOLD_EN(1'b0)) u_dut_s (
    .fpga_clk  (fpga_clk),
    .rst       (rst),
    .step_tick (step_tick),
    .bus       (bus_s)
  );

  assign bus_s.cmd_valid = bus.cmd_valid;
  assign bus_s.cmd_steps = bus.cmd_steps;
  assign bus_s.cmd_dir   = bus.cmd_dir;
  assign bus_s.cmd_half  = bus.cmd_half;
  assign bus_s.cmd_div   = bus.cmd_div;
  assign bus_s.abort     = bus.abort;

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Spec-level view: mode 0 = idle, 1 = moving, 2 = reporting completion.
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int     m_mode = 0;
  int     m_idx = 0, m_left = 0, m_div = 0, m_cnt = 0;
  bit     m_dir = 0, m_half = 0, m_hold = 0, m_moved = 0, m_ab = 0;
  longint m_pos = 0;

  always @(posedge fpga_clk) begin
    if (rst) begin
      m_mode = 0; m_idx = 0; m_pos = 0; m_hold = 0; m_moved = 0; m_ab = 0;
    end else begin
      case (m_mode)
        0: if (bus.cmd_valid) begin
          m_dir = bus.cmd_dir; m_half = bus.cmd_half; m_div = int'(bus.cmd_div);
          m_left = int'(bus.cmd_steps); m_cnt = 0; m_moved = 0; m_ab = 0;
          m_mode = (m_left == 0) ? 2 : 1;
        end
        1: begin
          if (bus.abort) begin
            m_ab = 1; m_mode = 2;
          end else if (step_tick) begin
            if (m_cnt == m_div) begin
              int inc;
              inc = m_half ? 1 : 2;
              m_idx = m_dir ? (m_idx + inc) % 8 : (m_idx + 8 - inc) % 8;
              m_pos = m_dir ? m_pos + inc : m_pos - inc;
              m_hold = 1; m_moved = 1; m_left--; m_cnt = 0;
              if (m_left == 0) m_mode = 2;
            end else begin
              m_cnt++;
            end
          end
        end
        default: begin
          m_mode = 0; m_moved = 0; m_ab = 0;
        end
      endcase
    end
  end

  // ---------------- monitor + per-cycle compare ----------------
  logic [3:0] obs_q[$];
  int         obs_tick[$];
  logic [3:0] last_coil = 4'b0000;
  int         tick_num = 0;
  int         done_cnt = 0;
  bit         last_ab = 0;

  always @(posedge fpga_clk) begin
    #1;
    if (step_tick) tick_num++;
    if (bus.coil != last_coil) begin
      obs_q.push_back(bus.coil);
      obs_tick.push_back(tick_num);
    end
    last_coil = bus.coil;
    if (bus.done) begin
      done_cnt++;
      last_ab = bus.aborted;
    end
    if (chk_en) begin
      check("cmd_ready", bus.cmd_ready, m_mode == 0);
      check("busy",      bus.busy,      m_mode != 0);
      check("done",      bus.done,      m_mode == 2);
      check("coil",      bus.coil,      m_hold ? tbl[m_idx] : 4'b0000);
      check("pos",       unsigned'(bus.pos), unsigned'(32'(m_pos)));
      check("s_done",    bus_s.done,    m_mode == 2);
      check("s_coil",    bus_s.coil,    m_moved ? tbl[m_idx] : 4'b0000);
      check("s_pos",     unsigned'(bus_s.pos), unsigned'(4'(m_pos)));
      if (m_mode == 2) begin
        check("aborted",   bus.aborted,   m_ab);
        check("s_aborted", bus_s.aborted, m_ab);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; step_tick = 1'b0; bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge fpga_clk);
    rst = 1'b0;
  endtask

  task automatic send_cmd(input int steps, input bit dir, input bit half, input int div);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = 16'(steps);
    bus.cmd_dir   = dir;
    bus.cmd_half  = half;
    bus.cmd_div   = 8'(div);
    @(negedge fpga_clk);
    bus.cmd_valid = 1'b0;
    // Scramble the fields: the sequencer must not look at them again.
    bus.cmd_steps = 16'($urandom_range(0, 65535));
    bus.cmd_dir   = 1'($urandom_range(0, 1));
    bus.cmd_half  = 1'($urandom_range(0, 1));
    bus.cmd_div   = 8'($urandom_range(0, 255));
  endtask

  task automatic tick_once(input int gap, input bit ab);
    repeat (gap - 1) @(negedge fpga_clk);
    step_tick = 1'b1;
    bus.abort = ab;
    @(negedge fpga_clk);
    step_tick = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge fpga_clk);
      n++;
    end
    check("wait_idle_timeout", bus.busy, 1'b0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [3:0] exp_q[$];
  int ob, tb0, db;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_steps = '0; bus.cmd_dir = 1'b0;
    bus.cmd_half = 1'b0; bus.cmd_div = '0; bus.abort = 1'b0;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_coil",      bus.coil,      4'b0000);
    check("rst_pos",       unsigned'(bus.pos), 32'd0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_done",      bus.done,      1'b0);

    // 1: four forward half-steps, tick every 10 cycles
    ob = obs_q.size(); db = done_cnt;
    send_cmd(4, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) tick_once(10, 1'b0);
    check("t1_done", bus.done, 1'b1);
    @(negedge fpga_clk);
    check("t1_ready_after_done", bus.cmd_ready, 1'b1);
    exp_q = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
    check("t1_nchanges", obs_q.size() - ob, 4);
    for (int i = 0; i < 4 && ob + i < obs_q.size(); i++)
      check("t1_coil_seq", obs_q[ob + i], exp_q[i]);
    check("t1_pos", unsigned'(bus.pos), 32'd4);
    check("t1_done_cnt", done_cnt - db, 1);
    check("t1_aborted", last_ab, 1'b0);

    // 2: three reverse full-steps with div=2
    do_reset();
    ob = obs_q.size(); tb0 = tick_num;
    send_cmd(3, 1'b0, 1'b0, 2);
    for (int i = 0; i < 9; i++) tick_once(3, 1'b0);
    check("t2_done", bus.done, 1'b1);
    exp_q = '{4'b0001, 4'b0010, 4'b0100};
    check("t2_nchanges", obs_q.size() - ob, 3);
    for (int i = 0; i < 3 && ob + i < obs_q.size(); i++) begin
      check("t2_coil_seq", obs_q[ob + i], exp_q[i]);
      check("t2_step_tick_no", obs_tick[ob + i] - tb0, 3 * (i + 1));
    end
    check("t2_pos", unsigned'(bus.pos), 32'hFFFF_FFFA);
    wait_idle(10);

    // 3: zero-step command
    do_reset();
    db = done_cnt;
    send_cmd(0, 1'b1, 1'b1, 5);
    check("t3_done_next_cycle", bus.done, 1'b1);
    check("t3_aborted", bus.aborted, 1'b0);
    check("t3_coil", bus.coil, 4'b0000);
    check("t3_pos", unsigned'(bus.pos), 32'd0);
    @(negedge fpga_clk);
    check("t3_ready", bus.cmd_ready, 1'b1);

    // 4: abort on the 4th tick of a 10-step move
    do_reset();
    db = done_cnt;
    send_cmd(10, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) tick_once(4, 1'b0);
    tick_once(4, 1'b1);
    check("t4_done", bus.done, 1'b1);
    check("t4_aborted", bus.aborted, 1'b1);
    check("t4_pos", unsigned'(bus.pos), 32'd3);
    check("t4_coil", bus.coil, 4'b0110);
    @(negedge fpga_clk);
    bus.abort = 1'b1;
    @(negedge fpga_clk);
    bus.abort = 1'b0;
    @(negedge fpga_clk);
    check("t4_idle_abort_ready", bus.cmd_ready, 1'b1);
    check("t4_idle_abort_pos", unsigned'(bus.pos), 32'd3);
    check("t4_done_cnt", done_cnt - db, 1);

    // 5: POS_W=4 wrap and HOLD_EN=0 release
    do_reset();
    send_cmd(7, 1'b1, 1'b1, 0);
    for (int i = 0; i < 7; i++) tick_once(2, 1'b0);
    wait_idle(10);
    check("t5_s_pos7", unsigned'(bus_s.pos), 4'd7);
    send_cmd(1, 1'b1, 1'b1, 0);
    tick_once(2, 1'b0);
    check("t5_s_done", bus_s.done, 1'b1);
    check("t5_s_pos_wrap", unsigned'(bus_s.pos), 4'b1000);
    check("t5_pos", unsigned'(bus.pos), 32'd8);
    @(negedge fpga_clk);
    check("t5_s_coil_released", bus_s.coil, 4'b0000);
    check("t5_coil_held", bus.coil, 4'b1000);

    // 6: reset in the middle of an 8-step move
    do_reset();
    db = done_cnt;
    send_cmd(8, 1'b1, 1'b1, 0);
    for (int i = 0; i < 2; i++) tick_once(3, 1'b0);
    check("t6_pos_mid", unsigned'(bus.pos), 32'd2);
    rst = 1'b1;
    @(negedge fpga_clk);
    check("t6_coil", bus.coil, 4'b0000);
    check("t6_pos", unsigned'(bus.pos), 32'd0);
    check("t6_ready", bus.cmd_ready, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge fpga_clk);
    check("t6_no_done", done_cnt - db, 0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      step_tick     = 1'($urandom_range(0, 1));
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_steps = ($urandom_range(0, 9) == 0) ? 16'd20 : 16'($urandom_range(0, 6));
      bus.cmd_dir   = 1'($urandom_range(0, 1));
      bus.cmd_half  = 1'($urandom_range(0, 1));
      bus.cmd_div   = 8'($urandom_range(0, 2));
      bus.abort     = ($urandom_range(0, 59) == 0);
      @(negedge fpga_clk);
    end
    rst = 1'b0; step_tick = 1'b0; bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge fpga_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
